hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Hazard and pipeline-sequencing controller for the 5-stage non-forwarding RV32I pipeline (IF/ID/EX/MEM/WB). It tracks destination registers of in-flight instructions in a shadow scoreboard. From that it generates PC/IF-ID enables, bubble insertion and flushes for RAW hazards, EX-stage redirects and memory stalls. It also produces the WB commit strobe (drives the insn_vld debug output) and saturating stall/flush performance counters.

Parameters:
WB_BYPASS, 1, 1 = regfile is write-through (ID reads same-cycle WB data), so WB stage is not checked for hazards; 0 = WB also checked
CNT_W, 32, width of performance counters

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_reset  in  1  synchronous reset, active-high
i_id_vld  in  1  valid instruction in ID
i_id_rs1  in  5  ID source register 1
i_id_rs2  in  5  ID source register 2
i_id_rs1_use  in  1  instruction reads rs1
i_id_rs2_use  in  1  instruction reads rs2
i_id_rd  in  5  ID destination register
i_id_rd_wren  in  1  instruction writes rd
i_ex_redirect  in  1  EX resolved taken branch/jump or mispredict; PC must load target
i_mem_stall  in  1  LSU/memory not ready; freeze whole pipeline
o_pc_en  out  1  PC register update enable
o_ifid_en  out  1  IF/ID register load enable
o_ifid_flush  out  1  clear IF/ID to bubble
o_idex_flush  out  1  load bubble into ID/EX
o_stall  out  1  RAW hazard stall this cycle
o_wb_commit  out  1  WB instruction retires this cycle (regfile write qualify, insn_vld)
o_stall_cnt  out  CNT_W  RAW stall cycle count
o_flush_cnt  out  CNT_W  accepted redirect count

Behaviour:
- Shadow stages EX, MEM, WB each hold {vld, rd, wren}. Entry with rd==0 treated as wren=0 on capture.
- match(r) = r!=0 & ((EX.vld&EX.wren&EX.rd==r) | (MEM.vld&MEM.wren&MEM.rd==r) | (!WB_BYPASS & WB.vld&WB.wren&WB.rd==r)).
- hazard = i_id_vld & ((i_id_rs1_use & match(rs1)) | (i_id_rs2_use & match(rs2))).
- Priority: reset > i_mem_stall > i_ex_redirect > hazard > normal.
- Reset (i_reset=1 at edge): all shadow vld=0, counters=0. While i_reset high, outputs forced: o_pc_en=0, o_ifid_en=0, o_ifid_flush=1, o_idex_flush=1, o_stall=0, o_wb_commit=0.
- mem_stall: o_pc_en=0, o_ifid_en=0, both flushes 0, o_stall=0, shadows hold, o_wb_commit=0, counters hold. Redirect/hazard ignored (sources hold their state and re-assert).
- redirect (no mem_stall): o_pc_en=1, o_ifid_en=1, o_ifid_flush=1, o_idex_flush=1, o_stall=0. Shift: WB<=MEM, MEM<=EX, EX<=bubble. flush_cnt+1.
- hazard (no redirect/mem_stall): o_pc_en=0, o_ifid_en=0, o_ifid_flush=0, o_idex_flush=1, o_stall=1. Shift with EX<=bubble. stall_cnt+1.
- normal: o_pc_en=1, o_ifid_en=1, flushes 0. Shift with EX<={i_id_vld, i_id_rd, i_id_rd_wren & rd!=0}.
- o_wb_commit = WB.vld & ~i_mem_stall & ~i_reset (combinational from registered WB).
- All control outputs are combinational, same cycle as inputs. Zero added latency.
- Counters saturate at all-ones (no wrap).
- Stall length for back-to-back dependency: 2 cycles with WB_BYPASS=1, 3 with 0.
- Unused source (use=0) or rs==x0 never stalls. Redirect with a concurrent hazard: redirect wins, stall_cnt unchanged.

Test Plan:
- Reset: hold i_reset 3 cycles with i_id_vld=1 -> pc_en=0, both flushes=1, wb_commit=0. After release, counters=0 and no stall.
- RAW: addi x5 issued, next ID reads rs1=x5 -> o_stall=1 for exactly 2 cycles (WB_BYPASS=1), 3 cycles (=0). stall_cnt=2/3. Dependent issues next cycle.
- x0/unused: write rd=x0, then read rs1=x0; also rs2=x5 with rs2_use=0 -> no stall, stall_cnt=0.
- Redirect over hazard: hazard pending and i_ex_redirect=1 same cycle -> ifid_flush=1, idex_flush=1, pc_en=1, o_stall=0, flush_cnt=1, stall_cnt unchanged.
- mem_stall: 4 valid insns in flight, assert i_mem_stall 5 cycles -> pc_en=0, wb_commit=0, shadows frozen. After release, commits resume in order, total commits=4.
- Saturation: CNT_W=4, 20 hazard cycles -> o_stall_cnt stays 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage non-forwarding RV32I pipeline.
// A shadow scoreboard of EX/MEM/WB destinations drives stalls, flushes, commit and perf counters.
module hazard_ctrl #(
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_id_vld,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_rs1_use,
    input  logic             i_id_rs2_use,
    input  logic [4:0]       i_id_rd,
    input  logic             i_id_rd_wren,
    input  logic             i_ex_redirect,
    input  logic             i_mem_stall,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_stall,
    output logic             o_wb_commit,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic CHECK_WB = (WB_BYPASS == 0);

    logic             ex_vld_r, mem_vld_r, wb_vld_r;
    logic [4:0]       ex_rd_r, mem_rd_r, wb_rd_r;
    logic             ex_wren_r, mem_wren_r, wb_wren_r;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

    logic             rs1_match_s, rs2_match_s, hazard_s, redirect_s, insert_bubble_s;

    function automatic logic stage_hit(input logic vld, input logic wren,
                                       input logic [4:0] rd, input logic [4:0] r);
        stage_hit = vld & wren & (rd == r);
    endfunction

    function automatic logic reg_match(input logic [4:0] r,
                                       input logic ex_hit, input logic mem_hit,
                                       input logic wb_hit);
        reg_match = (r != 5'd0) & (ex_hit | mem_hit | (CHECK_WB & wb_hit));
    endfunction

    // Source-register match against in-flight destinations and resulting hazard.
    always_comb begin
        rs1_match_s = reg_match(i_id_rs1,
                                stage_hit(ex_vld_r, ex_wren_r, ex_rd_r, i_id_rs1),
                                stage_hit(mem_vld_r, mem_wren_r, mem_rd_r, i_id_rs1),
                                stage_hit(wb_vld_r, wb_wren_r, wb_rd_r, i_id_rs1));
        rs2_match_s = reg_match(i_id_rs2,
                                stage_hit(ex_vld_r, ex_wren_r, ex_rd_r, i_id_rs2),
                                stage_hit(mem_vld_r, mem_wren_r, mem_rd_r, i_id_rs2),
                                stage_hit(wb_vld_r, wb_wren_r, wb_rd_r, i_id_rs2));
        hazard_s    = i_id_vld & ((i_id_rs1_use & rs1_match_s) | (i_id_rs2_use & rs2_match_s));
        redirect_s  = i_ex_redirect & ~i_mem_stall;
        insert_bubble_s = redirect_s | hazard_s;
    end

    // Priority decode of pipeline enables and flushes: reset, mem stall, redirect, hazard, normal.
    always_comb begin
        o_pc_en      = 1'b1;
        o_ifid_en    = 1'b1;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        o_stall      = 1'b0;
        if (i_reset) begin
            o_pc_en      = 1'b0;
            o_ifid_en    = 1'b0;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if (i_mem_stall) begin
            o_pc_en   = 1'b0;
            o_ifid_en = 1'b0;
        end else if (i_ex_redirect) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if (hazard_s) begin
            o_pc_en      = 1'b0;
            o_ifid_en    = 1'b0;
            o_idex_flush = 1'b1;
            o_stall      = 1'b1;
        end else begin
            o_pc_en = 1'b1;
        end
        o_wb_commit = wb_vld_r & ~i_mem_stall & ~i_reset;
    end

    // Shadow scoreboard shift; rd==x0 is captured as a non-writing entry.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_vld_r   <= 1'b0;
            ex_rd_r    <= 5'd0;
            ex_wren_r  <= 1'b0;
            mem_vld_r  <= 1'b0;
            mem_rd_r   <= 5'd0;
            mem_wren_r <= 1'b0;
            wb_vld_r   <= 1'b0;
            wb_rd_r    <= 5'd0;
            wb_wren_r  <= 1'b0;
        end else if (!i_mem_stall) begin
            wb_vld_r   <= mem_vld_r;
            wb_rd_r    <= mem_rd_r;
            wb_wren_r  <= mem_wren_r;
            mem_vld_r  <= ex_vld_r;
            mem_rd_r   <= ex_rd_r;
            mem_wren_r <= ex_wren_r;
            if (insert_bubble_s) begin
                ex_vld_r  <= 1'b0;
                ex_rd_r   <= 5'd0;
                ex_wren_r <= 1'b0;
            end else begin
                ex_vld_r  <= i_id_vld;
                ex_rd_r   <= i_id_rd;
                ex_wren_r <= i_id_rd_wren & (i_id_rd != 5'd0);
            end
        end
    end

    // Saturating performance counters; a redirect masks any concurrent hazard.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (!i_mem_stall) begin
            if (i_ex_redirect) begin
                if (flush_cnt_r != {CNT_W{1'b1}}) begin
                    flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else if (hazard_s) begin
                if (stall_cnt_r != {CNT_W{1'b1}}) begin
                    stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign o_stall_cnt = stall_cnt_r;
    assign o_flush_cnt = flush_cnt_r;

endmodule
